// File: rtl/sdram_burst_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sdram_pkg                                                        |
// | Shared constants and FSM state encoding for the burst scheduler. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package sdram_pkg;

  localparam int c_burst_len_dflt = 8;

  localparam logic [2:0] c_state_idle    = 3'd0;
  localparam logic [2:0] c_state_wr_req  = 3'd1;
  localparam logic [2:0] c_state_wr_data = 3'd2;
  localparam logic [2:0] c_state_rd_req  = 3'd3;
  localparam logic [2:0] c_state_rd_data = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = c_state_idle,
    S_WR_REQ  = c_state_wr_req,
    S_WR_DATA = c_state_wr_data,
    S_RD_REQ  = c_state_rd_req,
    S_RD_DATA = c_state_rd_data
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sdram_burst_sched_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sdram_burst_sched_if                                             |
// | FIFO-side levels, FIFO strobes and command-core handshake.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface sdram_burst_sched_if #(
  parameter int ADDR_WIDTH  = 22,
  parameter int LEVEL_WIDTH = 10
);
  logic                   Enable;
  logic [LEVEL_WIDTH-1:0] Wr_Level;
  logic [LEVEL_WIDTH-1:0] Rd_Free;
  logic                   Wr_Fifo_Ren;
  logic                   Rd_Fifo_Wen;
  logic                   Sdr_Req;
  logic                   Sdr_Wr;
  logic [ADDR_WIDTH-1:0]  Sdr_Addr;
  logic                   Sdr_Ack;
  logic                   Sdr_Beat;
  logic [ADDR_WIDTH:0]    Stored;
  logic                   Busy;

  // slave = the scheduler, master = whatever drives FIFO levels and the core handshake
  modport slave (
    input  Enable, Wr_Level, Rd_Free, Sdr_Ack, Sdr_Beat,
    output Wr_Fifo_Ren, Rd_Fifo_Wen, Sdr_Req, Sdr_Wr, Sdr_Addr, Stored, Busy
  );

  modport master (
    output Enable, Wr_Level, Rd_Free, Sdr_Ack, Sdr_Beat,
    input  Wr_Fifo_Ren, Rd_Fifo_Wen, Sdr_Req, Sdr_Wr, Sdr_Addr, Stored, Busy
  );
endinterface
`default_nettype wire

// File: rtl/sdram_burst_sched_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sdram_burst_arb                                                  |
// | Combinational round-robin pick between write and read bursts.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sdram_burst_arb (
  input  logic wr_ok,
  input  logic rd_ok,
  input  logic Last_Wr,
  input  logic Enable,
  output logic grant_wr,
  output logic grant_rd
);
  // When both are eligible the side that did not win last time goes next
  assign grant_wr = Enable & wr_ok & (~rd_ok | ~Last_Wr);
  assign grant_rd = Enable & rd_ok & (~wr_ok |  Last_Wr);
endmodule
`default_nettype wire

// File: rtl/sdram_burst_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sdram_burst_sched                                                |
// | One-at-a-time SDRAM burst scheduler with pointers and fill level.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sdram_burst_sched
  import sdram_pkg::*;
#(
  parameter int BURST_LEN   = c_burst_len_dflt,
  parameter int ADDR_WIDTH  = 22,
  parameter int LEVEL_WIDTH = 10
) (
  input  logic               Clk,
  input  logic               Rst_n,
  sdram_burst_sched_if.slave bus
);

  localparam int                    c_cnt_w        = $clog2(BURST_LEN);
  localparam logic [LEVEL_WIDTH-1:0] c_lvl_burst   = LEVEL_WIDTH'(BURST_LEN);
  localparam logic [ADDR_WIDTH:0]   c_stored_burst = (ADDR_WIDTH+1)'(BURST_LEN);
  localparam logic [ADDR_WIDTH:0]   c_stored_limit = (ADDR_WIDTH+1)'((64'd1 << ADDR_WIDTH) - 64'(BURST_LEN));
  localparam logic [ADDR_WIDTH-1:0] c_ptr_burst    = ADDR_WIDTH'(BURST_LEN);
  localparam logic [c_cnt_w-1:0]    c_last_beat    = c_cnt_w'(BURST_LEN - 1);
  localparam logic [c_cnt_w-1:0]    c_cnt_one      = c_cnt_w'(1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_stored;
  logic [c_cnt_w-1:0]    r_beat_cnt;
  logic                  r_last_wr;
  logic                  r_req;
  logic                  r_wr;

  logic w_wr_ok;
  logic w_rd_ok;
  logic w_grant_wr;
  logic w_grant_rd;

  assign w_wr_ok = (bus.Wr_Level >= c_lvl_burst) && (r_stored <= c_stored_limit);
  assign w_rd_ok = (bus.Rd_Free  >= c_lvl_burst) && (r_stored >= c_stored_burst);

  sdram_burst_arb u_arb (
    .wr_ok    (w_wr_ok),
    .rd_ok    (w_rd_ok),
    .Last_Wr  (r_last_wr),
    .Enable   (bus.Enable),
    .grant_wr (w_grant_wr),
    .grant_rd (w_grant_rd)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_addr     <= '0;
      r_stored   <= '0;
      r_beat_cnt <= '0;
      r_last_wr  <= 1'b0;
      r_req      <= 1'b0;
      r_wr       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_wr) begin
            r_state   <= S_WR_REQ;
            r_req     <= 1'b1;
            r_wr      <= 1'b1;
            r_addr    <= r_wr_ptr;
            r_last_wr <= 1'b1;
          end else if (w_grant_rd) begin
            r_state   <= S_RD_REQ;
            r_req     <= 1'b1;
            r_wr      <= 1'b0;
            r_addr    <= r_rd_ptr;
            r_last_wr <= 1'b0;
          end
        end
        // Beats arriving before the ack are not part of this burst
        S_WR_REQ, S_RD_REQ: begin
          if (bus.Sdr_Ack) begin
            r_req      <= 1'b0;
            r_beat_cnt <= '0;
            r_state    <= (r_state == S_WR_REQ) ? S_WR_DATA : S_RD_DATA;
          end
        end
        S_WR_DATA: begin
          if (bus.Sdr_Beat) begin
            if (r_beat_cnt == c_last_beat) begin
              r_state  <= S_IDLE;
              r_wr_ptr <= r_wr_ptr + c_ptr_burst;
              r_stored <= r_stored + c_stored_burst;
            end else begin
              r_beat_cnt <= r_beat_cnt + c_cnt_one;
            end
          end
        end
        S_RD_DATA: begin
          if (bus.Sdr_Beat) begin
            if (r_beat_cnt == c_last_beat) begin
              r_state  <= S_IDLE;
              r_rd_ptr <= r_rd_ptr + c_ptr_burst;
              r_stored <= r_stored - c_stored_burst;
            end else begin
              r_beat_cnt <= r_beat_cnt + c_cnt_one;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Sdr_Req     = r_req;
  assign bus.Sdr_Wr      = r_wr;
  assign bus.Sdr_Addr    = r_addr;
  assign bus.Stored      = r_stored;
  assign bus.Busy        = (r_state != S_IDLE);
  assign bus.Wr_Fifo_Ren = (r_state == S_WR_DATA) & bus.Sdr_Beat;
  assign bus.Rd_Fifo_Wen = (r_state == S_RD_DATA) & bus.Sdr_Beat;

endmodule
`default_nettype wire
